// File: rtl/sine_pkg.sv
// Shared widths, types and constants for the sine DAC generator.
package sine_pkg;
  localparam int SAMPLE_W  = 10;
  localparam int PHASE_W   = 9;
  localparam int ROM_DEPTH = 128;
  localparam int ROM_IDX_W = $clog2(ROM_DEPTH);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]  phase_t;

  localparam sample_t MIDSCALE = sample_t'(512);
endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table: Q[k] = round(511*sin(2*pi*(k+0.5)/512)), k = 0..127.
module sine_quarter_rom
  import sine_pkg::*;
(
  input  logic [ROM_IDX_W-1:0] i_index,
  output logic [SAMPLE_W-2:0]  o_q
);

  always_comb begin
    o_q = '0;
    case (i_index)
      7'd0:   o_q = 9'd3;   7'd1:   o_q = 9'd9;   7'd2:   o_q = 9'd16;  7'd3:   o_q = 9'd22;
      7'd4:   o_q = 9'd28;  7'd5:   o_q = 9'd34;  7'd6:   o_q = 9'd41;  7'd7:   o_q = 9'd47;
      7'd8:   o_q = 9'd53;  7'd9:   o_q = 9'd59;  7'd10:  o_q = 9'd66;  7'd11:  o_q = 9'd72;
      7'd12:  o_q = 9'd78;  7'd13:  o_q = 9'd84;  7'd14:  o_q = 9'd90;  7'd15:  o_q = 9'd97;
      7'd16:  o_q = 9'd103; 7'd17:  o_q = 9'd109; 7'd18:  o_q = 9'd115; 7'd19:  o_q = 9'd121;
      7'd20:  o_q = 9'd127; 7'd21:  o_q = 9'd133; 7'd22:  o_q = 9'd139; 7'd23:  o_q = 9'd145;
      7'd24:  o_q = 9'd151; 7'd25:  o_q = 9'd157; 7'd26:  o_q = 9'd163; 7'd27:  o_q = 9'd169;
      7'd28:  o_q = 9'd175; 7'd29:  o_q = 9'd181; 7'd30:  o_q = 9'd187; 7'd31:  o_q = 9'd193;
      7'd32:  o_q = 9'd198; 7'd33:  o_q = 9'd204; 7'd34:  o_q = 9'd210; 7'd35:  o_q = 9'd216;
      7'd36:  o_q = 9'd221; 7'd37:  o_q = 9'd227; 7'd38:  o_q = 9'd233; 7'd39:  o_q = 9'd238;
      7'd40:  o_q = 9'd244; 7'd41:  o_q = 9'd249; 7'd42:  o_q = 9'd255; 7'd43:  o_q = 9'd260;
      7'd44:  o_q = 9'd265; 7'd45:  o_q = 9'd271; 7'd46:  o_q = 9'd276; 7'd47:  o_q = 9'd281;
      7'd48:  o_q = 9'd286; 7'd49:  o_q = 9'd292; 7'd50:  o_q = 9'd297; 7'd51:  o_q = 9'd302;
      7'd52:  o_q = 9'd307; 7'd53:  o_q = 9'd312; 7'd54:  o_q = 9'd317; 7'd55:  o_q = 9'd322;
      7'd56:  o_q = 9'd327; 7'd57:  o_q = 9'd331; 7'd58:  o_q = 9'd336; 7'd59:  o_q = 9'd341;
      7'd60:  o_q = 9'd345; 7'd61:  o_q = 9'd350; 7'd62:  o_q = 9'd355; 7'd63:  o_q = 9'd359;
      7'd64:  o_q = 9'd364; 7'd65:  o_q = 9'd368; 7'd66:  o_q = 9'd372; 7'd67:  o_q = 9'd377;
      7'd68:  o_q = 9'd381; 7'd69:  o_q = 9'd385; 7'd70:  o_q = 9'd389; 7'd71:  o_q = 9'd393;
      7'd72:  o_q = 9'd397; 7'd73:  o_q = 9'd401; 7'd74:  o_q = 9'd405; 7'd75:  o_q = 9'd409;
      7'd76:  o_q = 9'd412; 7'd77:  o_q = 9'd416; 7'd78:  o_q = 9'd420; 7'd79:  o_q = 9'd423;
      7'd80:  o_q = 9'd427; 7'd81:  o_q = 9'd430; 7'd82:  o_q = 9'd433; 7'd83:  o_q = 9'd437;
      7'd84:  o_q = 9'd440; 7'd85:  o_q = 9'd443; 7'd86:  o_q = 9'd446; 7'd87:  o_q = 9'd449;
      7'd88:  o_q = 9'd452; 7'd89:  o_q = 9'd455; 7'd90:  o_q = 9'd458; 7'd91:  o_q = 9'd461;
      7'd92:  o_q = 9'd463; 7'd93:  o_q = 9'd466; 7'd94:  o_q = 9'd468; 7'd95:  o_q = 9'd471;
      7'd96:  o_q = 9'd473; 7'd97:  o_q = 9'd476; 7'd98:  o_q = 9'd478; 7'd99:  o_q = 9'd480;
      7'd100: o_q = 9'd482; 7'd101: o_q = 9'd484; 7'd102: o_q = 9'd486; 7'd103: o_q = 9'd488;
      7'd104: o_q = 9'd490; 7'd105: o_q = 9'd492; 7'd106: o_q = 9'd493; 7'd107: o_q = 9'd495;
      7'd108: o_q = 9'd496; 7'd109: o_q = 9'd498; 7'd110: o_q = 9'd499; 7'd111: o_q = 9'd501;
      7'd112: o_q = 9'd502; 7'd113: o_q = 9'd503; 7'd114: o_q = 9'd504; 7'd115: o_q = 9'd505;
      7'd116: o_q = 9'd506; 7'd117: o_q = 9'd507; 7'd118: o_q = 9'd508; 7'd119: o_q = 9'd508;
      7'd120: o_q = 9'd509; 7'd121: o_q = 9'd509; 7'd122: o_q = 9'd510; 7'd123: o_q = 9'd510;
      7'd124: o_q = 9'd511; 7'd125: o_q = 9'd511; 7'd126: o_q = 9'd511; 7'd127: o_q = 9'd511;
    endcase
  end

endmodule

// File: rtl/sine_dac_gen.sv
// Free-running 512-step sine generator driving a 10-bit resistor-ladder DAC.
// Prescaler gates a phase counter; quarter-wave ROM output is unfolded and registered.
module sine_dac_gen
  import sine_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic _9b,
  output logic _6a,
  output logic _4a,
  output logic _2a,
  output logic _0a,
  output logic _5a,
  output logic _3b,
  output logic _49a,
  output logic _45a,
  output logic _48b
);

  localparam int PRE_W = 16;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]     r_prescaler;
  phase_t               r_phase;
  sample_t              r_sample;
  logic                 w_tick;
  logic [1:0]           w_quad;
  logic [ROM_IDX_W-1:0] w_p;
  logic [ROM_IDX_W-1:0] w_rom_idx;
  logic [SAMPLE_W-2:0]  w_q;
  sample_t              w_next;

  assign w_tick = (r_prescaler == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler <= '0;
    end else if (w_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + PRE_W'(1);
    end
  end

  assign w_quad = r_phase[PHASE_W-1 -: 2];
  assign w_p    = r_phase[ROM_IDX_W-1:0];

  // Odd quadrants read the table backwards: 127 - p is just ~p in 7 bits.
  assign w_rom_idx = w_quad[0] ? ~w_p : w_p;

  sine_quarter_rom u_rom (
    .i_index (w_rom_idx),
    .o_q     (w_q)
  );

  assign w_next = w_quad[1] ? (MIDSCALE - sample_t'(w_q)) : (MIDSCALE + sample_t'(w_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= '0;
      r_sample <= MIDSCALE;
    end else if (w_tick) begin
      r_phase  <= r_phase + phase_t'(1);
      r_sample <= w_next;
    end
  end

  assign {_9b, _6a, _4a, _2a, _0a, _5a, _3b, _49a, _45a, _48b} = r_sample;

endmodule

// File: tb/tb_sine_dac_gen.sv
// Bench for sine_dac_gen: CLK_DIV=1 and CLK_DIV=4 instances checked against a real-valued sine model.
module tb_sine_dac_gen;

  localparam real PI     = 3.14159265358979323846;
  localparam int  N_RUN  = 2056;
  localparam int  N_VEC  = 10;

  typedef struct {
    int          phase;
    logic [9:0]  expected;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [9:0] w_s1;
  wire  [9:0] w_s4;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] q_sb1[$];
  logic [9:0] q_sb4[$];
  logic [9:0] cap[0:1023];
  vec_t       vecs[N_VEC];

  always #5 clk = ~clk;

  sine_dac_gen #(.CLK_DIV(1)) dut1 (
    .clk (clk), .rst (rst),
    ._9b (w_s1[9]), ._6a (w_s1[8]), ._4a (w_s1[7]), ._2a (w_s1[6]), ._0a (w_s1[5]),
    ._5a (w_s1[4]), ._3b (w_s1[3]), ._49a (w_s1[2]), ._45a (w_s1[1]), ._48b (w_s1[0])
  );

  sine_dac_gen #(.CLK_DIV(4)) dut4 (
    .clk (clk), .rst (rst),
    ._9b (w_s4[9]), ._6a (w_s4[8]), ._4a (w_s4[7]), ._2a (w_s4[6]), ._0a (w_s4[5]),
    ._5a (w_s4[4]), ._3b (w_s4[3]), ._49a (w_s4[2]), ._45a (w_s4[1]), ._48b (w_s4[0])
  );

  function automatic logic [9:0] golden(input int n);
    real v;
    v = 512.0 + 511.0 * $sin(2.0 * PI * (real'(n % 512) + 0.5) / 512.0);
    return 10'($rtoi(v + 0.5));
  endfunction

  // Expected CLK_DIV=4 output after the c-th rising edge following reset release.
  function automatic logic [9:0] model_div4(input int c);
    int t;
    t = (c + 1) / 4;
    return (t == 0) ? 10'd512 : golden(t - 1);
  endfunction

  task automatic check(input string name, input int idx, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [9:0] e;

    vecs[0] = '{0,   10'd515};
    vecs[1] = '{1,   10'd521};
    vecs[2] = '{2,   10'd528};
    vecs[3] = '{64,  10'd876};
    vecs[4] = '{127, 10'd1023};
    vecs[5] = '{128, 10'd1023};
    vecs[6] = '{255, 10'd515};
    vecs[7] = '{256, 10'd509};
    vecs[8] = '{383, 10'd1};
    vecs[9] = '{511, 10'd509};

    // Reset held for three clocks: both instances at midscale.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_div1", i, w_s1, 10'd512);
      check("reset_div4", i, w_s4, 10'd512);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < N_RUN; c++) begin
      q_sb1.push_back(golden(c));
      q_sb4.push_back(model_div4(c));
      @(posedge clk);
      #1;
      e = q_sb1.pop_front();
      check("sb_div1", c, w_s1, e);
      e = q_sb4.pop_front();
      check("sb_div4", c, w_s4, e);
      if (c < 1024) cap[c] = w_s1;
      if (c == 127) check("pins_all_high", c, w_s1, 10'h3FF);
      if (c == 384) check("pins_lsb_only", c, w_s1, 10'h001);
    end

    for (int i = 0; i < N_VEC; i++) begin
      check("vec", vecs[i].phase, cap[vecs[i].phase], vecs[i].expected);
      check("vec_wrap", vecs[i].phase + 512, cap[vecs[i].phase + 512], vecs[i].expected);
    end

    // Restart, run to phase 200, then reset asynchronously between edges.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 200; c++) begin
      @(posedge clk);
    end
    #1;
    check("phase200", 200, w_s1, golden(200));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_div1", 0, w_s1, 10'd512);
    check("async_rst_div4", 0, w_s4, 10'd512);
    @(posedge clk);
    #1;
    check("rst_held_div1", 0, w_s1, 10'd512);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("restart_div1", c, w_s1, golden(c));
      check("restart_div4", c, w_s4, model_div4(c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
